// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Op codes and FSM state encoding.
package shift_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_LSL  = 3'd1;
  localparam logic [2:0] OP_LSR  = 3'd2;
  localparam logic [2:0] OP_ASR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_RCL  = 3'd6;
  localparam logic [2:0] OP_RCR  = 3'd7;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Command and result bundle of the universal shift register.
// master drives commands, slave is the shifter.
interface univ_shift_reg_if #(
  parameter int MSB   = 8,
  parameter int AMT_W = $clog2(MSB) + 1
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [MSB-1:0]   din;
  logic             carry_in;
  logic             sin;
  logic [MSB-1:0]   out;
  logic             carry_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt,
    output din, carry_in, sin,
    input  cmd_ready, out, carry_out,
    input  busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt,
    input  din, carry_in, sin,
    output cmd_ready, out, carry_out,
    output busy, done
  );

endinterface

// File: rtl/univ_shift_reg_step.sv
// Single-bit shift/rotate step, purely combinational.
// Carry takes the bit shifted out of the register.
module shift_step
  import shift_pkg::*;
#(
  parameter int MSB = 8
) (
  input  logic [2:0]     i_op,
  input  logic [MSB-1:0] i_out,
  input  logic           i_c,
  input  logic           i_sin,
  output logic [MSB-1:0] o_out,
  output logic           o_c
);

  always_comb begin
    o_out = i_out;
    o_c   = i_c;
    unique case (i_op)
      OP_LOAD: begin
        o_out = i_out;
        o_c   = i_c;
      end
      OP_LSL: begin
        o_out = {i_out[MSB-2:0], i_sin};
        o_c   = i_out[MSB-1];
      end
      OP_LSR: begin
        o_out = {i_sin, i_out[MSB-1:1]};
        o_c   = i_out[0];
      end
      OP_ASR: begin
        o_out = {i_out[MSB-1], i_out[MSB-1:1]};
        o_c   = i_out[0];
      end
      OP_ROL: begin
        o_out = {i_out[MSB-2:0], i_out[MSB-1]};
        o_c   = i_out[MSB-1];
      end
      OP_ROR: begin
        o_out = {i_out[0], i_out[MSB-1:1]};
        o_c   = i_out[0];
      end
      OP_RCL: begin
        o_out = {i_out[MSB-2:0], i_c};
        o_c   = i_out[MSB-1];
      end
      OP_RCR: begin
        o_out = {i_c, i_out[MSB-1:1]};
        o_c   = i_out[0];
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift/rotate register, one bit position per enabled clock.
// Holds the FSM, step counter and data/carry registers.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int MSB   = 8,
  parameter int AMT_W = $clog2(MSB) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  univ_shift_reg_if.slave    bus
);

  state_t           r_state;
  state_t           w_nstate;
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_cnt;
  logic [MSB-1:0]   r_out;
  logic             r_c;
  logic             r_done;

  logic [MSB-1:0]   w_nout;
  logic             w_nc;
  logic             w_accept;
  logic             w_instant;
  logic             w_last;
  logic             w_fin;

  assign w_accept  = en & bus.cmd_valid & (r_state == S_IDLE);
  assign w_instant = (bus.cmd_op == OP_LOAD) | (bus.cmd_amt == '0);
  assign w_last    = (r_state == S_SHIFT) & en & (r_cnt == AMT_W'(1));
  assign w_fin     = (w_accept & w_instant) | w_last;

  shift_step #(.MSB(MSB)) u_step (
    .i_op  (r_op),
    .i_out (r_out),
    .i_c   (r_c),
    .i_sin (bus.sin),
    .o_out (w_nout),
    .o_c   (w_nc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept & ~w_instant) w_nstate = S_SHIFT;
      S_SHIFT: if (w_last) w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (r_state == S_IDLE);
    bus.busy      = (r_state == S_SHIFT);
    bus.done      = r_done;
    bus.out       = r_out;
    bus.carry_out = r_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op  <= OP_LOAD;
      r_cnt <= '0;
      r_out <= '0;
      r_c   <= 1'b0;
    end else if (en) begin
      if (w_accept) begin
        r_op  <= bus.cmd_op;
        r_cnt <= bus.cmd_amt;
        if (bus.cmd_op == OP_LOAD) begin
          r_out <= bus.din;
          r_c   <= bus.carry_in;
        end
      end else if (r_state == S_SHIFT) begin
        r_out <= w_nout;
        r_c   <= w_nc;
        r_cnt <= r_cnt - AMT_W'(1);
      end
    end
  end

  // Cleared even with en low so a frozen cycle cannot stretch the pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_done <= 1'b0;
    else       r_done <= w_fin;
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed test of univ_shift_reg at MSB=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_univ_shift_reg;
  import shift_pkg::*;

  logic clk;
  logic rstn;
  logic en;
  int   n_chk;
  int   n_err;
  int   cyc;

  univ_shift_reg_if #(.MSB(8), .AMT_W(4)) bus ();

  univ_shift_reg #(.MSB(8), .AMT_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(logic [2:0] op, logic [3:0] amt,
                       logic [7:0] d, logic ci);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_amt   = amt;
    bus.din       = d;
    bus.carry_in  = ci;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run(logic [2:0] op, logic [3:0] amt, output int n);
    issue(op, amt, 8'h00, 1'b0);
    n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    check("no_timeout", 32'(n < 50), 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rstn = 1'b0;
    en   = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_amt   = '0;
    bus.din       = '0;
    bus.carry_in  = 1'b0;
    bus.sin       = 1'b0;
    tick();
    check("rst_out", 32'(bus.out), 32'h00);
    check("rst_c", 32'(bus.carry_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    rstn = 1'b1;
    tick();

    issue(OP_LOAD, 4'd0, 8'b1011_0001, 1'b0);
    check("ld_out", 32'(bus.out), 32'hB1);
    check("ld_c", 32'(bus.carry_out), 32'd0);
    check("ld_done", 32'(bus.done), 32'd1);
    check("ld_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    check("ld_done_1cyc", 32'(bus.done), 32'd0);

    run(OP_ROR, 4'd3, cyc);
    check("ror3_busy", 32'(cyc), 32'd3);
    check("ror3_done", 32'(bus.done), 32'd1);
    check("ror3_ready", 32'(bus.cmd_ready), 32'd1);
    check("ror3_out", 32'(bus.out), 32'h36);
    check("ror3_c", 32'(bus.carry_out), 32'd0);
    tick();
    check("ror3_done_1cyc", 32'(bus.done), 32'd0);

    issue(OP_LOAD, 4'd0, 8'b1011_0001, 1'b0);
    run(OP_ASR, 4'd2, cyc);
    check("asr2_out", 32'(bus.out), 32'hEC);
    check("asr2_c", 32'(bus.carry_out), 32'd0);
    bus.sin = 1'b0;
    run(OP_LSR, 4'd1, cyc);
    check("lsr1_out", 32'(bus.out), 32'h76);
    check("lsr1_c", 32'(bus.carry_out), 32'd0);

    issue(OP_LOAD, 4'd0, 8'h01, 1'b1);
    check("ld_cin", 32'(bus.carry_out), 32'd1);
    run(OP_RCL, 4'd1, cyc);
    check("rcl1_out", 32'(bus.out), 32'h03);
    check("rcl1_c", 32'(bus.carry_out), 32'd0);
    run(OP_RCL, 4'd9, cyc);
    check("rcl9_busy", 32'(cyc), 32'd9);
    check("rcl9_out", 32'(bus.out), 32'h03);
    check("rcl9_c", 32'(bus.carry_out), 32'd0);

    issue(OP_LOAD, 4'd0, 8'h01, 1'b0);
    bus.sin = 1'b1;
    run(OP_LSL, 4'd3, cyc);
    check("lsl3_out", 32'(bus.out), 32'h0F);
    check("lsl3_c", 32'(bus.carry_out), 32'd0);
    bus.sin = 1'b0;
    tick();
    issue(OP_LSR, 4'd0, 8'hFF, 1'b1);
    check("amt0_busy", 32'(bus.busy), 32'd0);
    check("amt0_done", 32'(bus.done), 32'd1);
    check("amt0_out", 32'(bus.out), 32'h0F);
    check("amt0_c", 32'(bus.carry_out), 32'd0);
    tick();
    check("amt0_done_1cyc", 32'(bus.done), 32'd0);

    issue(OP_LOAD, 4'd0, 8'hA5, 1'b0);
    issue(OP_ROL, 4'd4, 8'h00, 1'b0);
    cyc = 32'(bus.busy);
    tick();
    cyc += 32'(bus.busy);
    tick();
    cyc += 32'(bus.busy);
    en = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LOAD;
    bus.din       = 8'hFF;
    tick();
    cyc += 32'(bus.busy);
    check("frz_done", 32'(bus.done), 32'd0);
    tick();
    cyc += 32'(bus.busy);
    check("frz_out", 32'(bus.out), 32'h96);
    check("frz_busy", 32'(bus.busy), 32'd1);
    en = 1'b1;
    tick();
    cyc += 32'(bus.busy);
    bus.cmd_valid = 1'b0;
    check("mid_cmd_ignored", 32'(bus.out), 32'h2D);
    tick();
    cyc += 32'(bus.busy);
    check("rol4_busy", cyc, 32'd6);
    check("rol4_done", 32'(bus.done), 32'd1);
    check("rol4_out", 32'(bus.out), 32'h5A);
    check("rol4_c", 32'(bus.carry_out), 32'd0);

    issue(OP_LOAD, 4'd0, 8'hF0, 1'b1);
    issue(OP_ROR, 4'd5, 8'h00, 1'b0);
    tick();
    tick();
    check("pre_rst_out", 32'(bus.out), 32'h3C);
    rstn = 1'b0;
    #1;
    check("abort_out", 32'(bus.out), 32'h00);
    check("abort_c", 32'(bus.carry_out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_rst_done", 32'(bus.done), 32'd0);
    tick();
    check("post_rst_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift/rotate register, successor to the bidirectional shift register. Accepts commands over a valid/ready interface: parallel load, logical/arithmetic shift, rotate, and rotate-through-carry, with a multi-bit shift amount. Executes one bit position per enabled clock, so a shift by N occupies N cycles. Reports the result on busy/done. Used as the shared shift datapath for serialisers and the small ALU.

Parameters:
MSB, 8, register width in bits (≥2)
AMT_W, $clog2(MSB)+1 (4 at default), width of shift-amount field; all values 0..2^AMT_W-1 are legal

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  global advance enable; 0 freezes all state (reset still acts)
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (= state IDLE)
cmd_op  in  3  op code (see package)
cmd_amt  in  AMT_W  shift count; ignored for LOAD
din  in  MSB  parallel load data
carry_in  in  1  carry value loaded by LOAD
sin  in  1  serial fill bit for LSL/LSR, sampled at every shift edge
out  out  MSB  register contents
carry_out  out  1  carry flag register
busy  out  1  1 while in SHIFT state
done  out  1  one-cycle pulse after a command completes

Behaviour:
- Reset (rstn low, async): out=0, carry_out=0, state IDLE, busy=0, done=0, cmd_ready=1, count=0.
- States: IDLE, SHIFT. cmd_ready=(state==IDLE); busy=(state==SHIFT).
- Accept edge E0: cmd_valid & cmd_ready & en. Op, amt latched; count<=cmd_amt.
- LOAD (000): at E0, out<=din, carry<=carry_in; done=1 during the following cycle; stays IDLE.
- Shift ops, amt=0: no change to out/carry; done pulses the following cycle; stays IDLE.
- Shift ops, amt=N>0: go to SHIFT at E0. One bit step on each of edges E1..EN with en=1; count decrements. At EN, return to IDLE; done high for the cycle after EN. cmd_ready rises in the same cycle as done, so back-to-back commands are allowed.
- Per-step semantics (c = carry):
  - LSL 001: out<={out[MSB-2:0],sin}, c<=out[MSB-1].
  - LSR 010: out<={sin,out[MSB-1:1]}, c<=out[0].
  - ASR 011: out<={out[MSB-1],out[MSB-1:1]}, c<=out[0].
  - ROL 100: out<={out[MSB-2:0],out[MSB-1]}, c<=out[MSB-1].
  - ROR 101: out<={out[0],out[MSB-1:1]}, c<=out[0].
  - RCL 110: out<={out[MSB-2:0],c}, c<=out[MSB-1] (MSB+1-bit rotation).
  - RCR 111: out<={c,out[MSB-1:1]}, c<=out[0].
- Counts are executed literally; no clamping. ROL/ROR by MSB returns the original value; RCL/RCR by MSB+1 returns the original value and carry.
- en=0 in SHIFT: out, carry and count hold, busy stays 1, no done. en=0 on a would-be accept edge: not accepted.
- cmd_valid while busy: ignored (no queueing); input values are don't-care.
- done is registered and is never high in two consecutive cycles for one command.
- Reset mid-operation: command is aborted immediately, with no done pulse; reset values apply.

Decomposition:
- Package shift_pkg: op-code localparams OP_LOAD..OP_RCR, state encoding (IDLE, SHIFT).
- Sub-module shift_step: combinational single-bit step (op, out, c, sin -> next out, next c), parameter MSB. The top level holds the FSM, counter and registers.

Test Plan:
- LOAD din=8'b1011_0001, carry_in=0 -> next cycle out=8'b1011_0001, carry_out=0, done=1 for 1 cycle; then ROR amt=3 -> busy 3 cycles, out=8'b0011_0110, carry_out=0, done pulse.
- LOAD 8'b1011_0001; ASR amt=2 -> out=8'b1110_1100, carry_out=0; LSR amt=1 with sin=0 -> out=8'b0111_0110, carry_out=0.
- LOAD 8'b0000_0001, carry_in=1; RCL amt=1 -> out=8'b0000_0011, carry=0; then RCL amt=9 -> out=8'b0000_0011, carry=0 (full 9-bit wrap).
- LOAD 8'h01; LSL amt=3 with sin=1 held -> out=8'b0000_1111, carry=0; shift amt=0 -> out unchanged, done next cycle, busy never high.
- ROL amt=4 on 8'hA5 with en dropped for 2 cycles after the 2nd step -> busy lasts 6 cycles, out=8'h5A; a cmd_valid issued mid-operation is ignored.
- ROR amt=5 on 8'hF0; assert rstn=0 after the 2nd step -> out=0, carry=0, busy=0, no done; after release cmd_ready=1.
